// File: rtl/ifetch_queue_pkg.sv
// Shared types for the instruction fetch unit: fetch FSM encoding, the
// {pc, inst} queue entry and a few fetch-wide constants.
package rv32i_types;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_WAIT    = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int          FETCH_ENTRY_W  = 64;
    localparam logic [3:0]  IMEM_MASK_READ = 4'hF;
    localparam logic [3:0]  IMEM_MASK_NONE = 4'h0;
    localparam logic [31:0] WORD_STRIDE    = 32'd4;

    // Instruction addresses are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_queue_fifo.sv
// Circular buffer for fetched {pc, inst} pairs. Pointers wrap naturally
// because DEPTH is a power of two; flush empties the buffer and wins over
// any push or pop in the same cycle.
module fetch_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = FETCH_ENTRY_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    head_q;
    logic [AW-1:0]    head_d;
    logic [AW-1:0]    tail_q;
    logic [AW-1:0]    tail_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // Next-state for storage, pointers and occupancy; push and pop may coincide.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = {AW{1'b0}};
            tail_d  = {AW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            if (push) begin
                mem_d[tail_q] = push_data;
                tail_d        = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
            if (pop) begin
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            head_q  <= {AW{1'b0}};
            tail_q  <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_data = mem_q[head_q];
    assign count     = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: owns the fetch PC, issues one word read at a time,
// buffers responses in fetch_fifo and presents the head entry to decode.
// A flush redirects the PC, empties the buffer and swallows an in-flight
// response via the DISCARD state.
module ifetch_queue
    import rv32i_types::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        dec_stall,
    output logic        dec_valid,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t  state_q;
    fetch_state_t  state_d;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   fetch_pc_d;
    logic [31:0]   req_pc_q;
    logic [31:0]   req_pc_d;
    logic [3:0]    rmask_q;
    logic [3:0]    rmask_d;

    logic          fifo_push;
    logic          fifo_pop;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FETCH_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head_data (head_entry),
        .count     (fifo_count)
    );

    // Queue handshakes: a pop needs a valid head and no stall; only a live
    // response in WAIT is enqueued; flush suppresses both.
    always_comb begin
        fifo_pop        = dec_valid && !dec_stall && !flush;
        fifo_push       = (state_q == FETCH_WAIT) && imem_resp && !flush;
        push_entry.pc   = req_pc_q;
        push_entry.inst = imem_rdata;
        count_next      = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    end

    // Fetch FSM and PC bookkeeping; a new read is issued only when the
    // buffer will still have room, so a push can never overflow it.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (flush) begin
            fetch_pc_d = word_align(redirect_pc);
            case (state_q)
                FETCH_IDLE:    state_d = FETCH_IDLE;
                FETCH_WAIT:    state_d = imem_resp ? FETCH_IDLE : FETCH_DISCARD;
                FETCH_DISCARD: state_d = imem_resp ? FETCH_IDLE : FETCH_DISCARD;
                default:       state_d = FETCH_IDLE;
            endcase
        end else begin
            case (state_q)
                FETCH_IDLE: begin
                    if (count_next < DEPTH_C) begin
                        state_d  = FETCH_WAIT;
                        req_pc_d = fetch_pc_q;
                    end else begin
                        state_d = FETCH_IDLE;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_resp) begin
                        fetch_pc_d = req_pc_q + WORD_STRIDE;
                        if (count_next < DEPTH_C) begin
                            state_d  = FETCH_WAIT;
                            req_pc_d = req_pc_q + WORD_STRIDE;
                        end else begin
                            state_d = FETCH_IDLE;
                        end
                    end else begin
                        state_d = FETCH_WAIT;
                    end
                end
                FETCH_DISCARD: begin
                    if (imem_resp) begin
                        state_d = FETCH_IDLE;
                    end else begin
                        state_d = FETCH_DISCARD;
                    end
                end
                default: state_d = FETCH_IDLE;
            endcase
        end
        rmask_d = (state_d != FETCH_IDLE) ? IMEM_MASK_READ : IMEM_MASK_NONE;
    end

    // FSM, PC and read-mask registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            rmask_q    <= IMEM_MASK_NONE;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            rmask_q    <= rmask_d;
        end
    end

    // Decode-facing view of the queue head, zeroed when empty.
    always_comb begin
        dec_valid = (fifo_count != {CW{1'b0}});
        if (dec_valid) begin
            dec_pc   = head_entry.pc;
            dec_inst = head_entry.inst;
        end else begin
            dec_pc   = 32'h0;
            dec_inst = 32'h0;
        end
    end

    assign imem_addr  = req_pc_q;
    assign imem_rmask = rmask_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue. A queue-based reference model tracks
// which {pc, inst} pairs decode should see and which fetch address is live.
module tb_ifetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h1eceb000;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        dec_stall;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rmask  (imem_rmask),
        .imem_rdata  (imem_rdata),
        .imem_resp   (imem_resp),
        .dec_stall   (dec_stall),
        .dec_valid   (dec_valid),
        .dec_inst    (dec_inst),
        .dec_pc      (dec_pc)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] model_pc;
    logic [31:0] stale_addr;
    bit          stale;
    bit          mon_en;
    int          n_checks;
    int          n_fail;
    int          mem_lat;
    int          wait_ctr;
    int          n_resp;

    // One clock cycle: check DUT against the model, drive inputs (rmode 0 = no
    // response, 1 = memory with mem_lat wait cycles, 2 = forced response),
    // then advance the model across the edge.
    task automatic tick(input bit r, input bit fl, input logic [31:0] rpc, input bit st, input int rmode);
        logic [3:0]  rmask_pre;
        logic [31:0] data;
        bit          rsp;
        if (mon_en) begin
            n_checks++;
            if (dec_valid !== (exp_q.size() != 0)) begin
                n_fail++;
                $display("FAIL mon_valid: got %b expected %b", dec_valid, exp_q.size() != 0);
            end
            n_checks++;
            if (exp_q.size() != 0) begin
                if (dec_pc !== exp_q[0].pc || dec_inst !== exp_q[0].inst) begin
                    n_fail++;
                    $display("FAIL mon_head: got %h/%h expected %h/%h", dec_pc, dec_inst, exp_q[0].pc, exp_q[0].inst);
                end
            end else begin
                if (dec_pc !== 32'h0 || dec_inst !== 32'h0) begin
                    n_fail++;
                    $display("FAIL mon_empty_head: got %h/%h expected 0/0", dec_pc, dec_inst);
                end
            end
            n_checks++;
            if (stale) begin
                if (imem_rmask !== 4'hF || imem_addr !== stale_addr) begin
                    n_fail++;
                    $display("FAIL mon_discard: got %h/%h expected f/%h", imem_rmask, imem_addr, stale_addr);
                end
            end else if (imem_rmask === 4'hF) begin
                if (imem_addr !== model_pc) begin
                    n_fail++;
                    $display("FAIL mon_addr: got %h expected %h", imem_addr, model_pc);
                end
            end else if (imem_rmask !== 4'h0) begin
                n_fail++;
                $display("FAIL mon_rmask: got %h expected 0 or f", imem_rmask);
            end
            n_checks++;
            if (!stale && exp_q.size() == DEPTH && imem_rmask !== 4'h0) begin
                n_fail++;
                $display("FAIL mon_full_issue: got rmask %h expected 0 with full queue", imem_rmask);
            end
        end
        rmask_pre = imem_rmask;
        rsp  = (rmode == 2) || (rmode == 1 && imem_rmask === 4'hF && wait_ctr >= mem_lat);
        data = rsp ? $urandom : 32'h0;
        rst = r; flush = fl; redirect_pc = rpc; dec_stall = st;
        imem_resp = rsp; imem_rdata = data;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            model_pc = RESET_PC;
            stale    = 1'b0;
            mon_en   = 1'b1;
        end else if (fl) begin
            if (rmask_pre === 4'hF && !rsp) begin
                if (!stale) stale_addr = model_pc;
                stale = 1'b1;
            end else begin
                stale = 1'b0;
            end
            exp_q.delete();
            model_pc = {rpc[31:2], 2'b00};
        end else begin
            if (exp_q.size() != 0 && !st) void'(exp_q.pop_front());
            if (rsp && rmask_pre === 4'hF) begin
                if (stale) begin
                    stale = 1'b0;
                end else begin
                    exp_q.push_back('{model_pc, data});
                    model_pc = model_pc + 32'd4;
                    n_checks++;
                    if (exp_q.size() > DEPTH) begin
                        n_fail++;
                        $display("FAIL overflow: got %0d entries expected at most %0d", exp_q.size(), DEPTH);
                    end
                end
            end
        end
        if (rmask_pre === 4'hF && !rsp) wait_ctr++; else wait_ctr = 0;
        if (rsp) n_resp++;
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 32'h0, 1'b0, 0);
        tick(1'b1, 1'b0, 32'h0, 1'b0, 0);
        n_checks++;
        if (dec_valid !== 1'b0 || dec_inst !== 32'h0 || dec_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_dec: got %b/%h/%h expected 0/0/0", dec_valid, dec_inst, dec_pc);
        end
        n_checks++;
        if (imem_rmask !== 4'h0 || imem_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset_imem: got %h/%h expected 0/%h", imem_rmask, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        mem_lat = 0;
        tick(1'b1, 1'b0, 32'h0, 1'b0, 0);
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1);
        n_checks++;
        if (imem_rmask !== 4'hF || imem_addr !== RESET_PC || dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_first_req: got %h/%h/%b expected f/%h/0", imem_rmask, imem_addr, dec_valid, RESET_PC);
        end
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1);
        n_checks++;
        if (imem_addr !== RESET_PC + 32'd4 || dec_valid !== 1'b1 || dec_pc !== RESET_PC) begin
            n_fail++;
            $display("FAIL seq_second: got %h/%b/%h expected %h/1/%h", imem_addr, dec_valid, dec_pc, RESET_PC + 32'd4, RESET_PC);
        end
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1);
        n_checks++;
        if (imem_addr !== RESET_PC + 32'd8 || dec_pc !== RESET_PC + 32'd4) begin
            n_fail++;
            $display("FAIL seq_third: got %h/%h expected %h/%h", imem_addr, dec_pc, RESET_PC + 32'd8, RESET_PC + 32'd4);
        end
    endtask

    task automatic test_stall();
        mem_lat = 0;
        tick(1'b1, 1'b0, 32'h0, 1'b1, 0);
        n_resp = 0;
        repeat (10) tick(1'b0, 1'b0, 32'h0, 1'b1, 1);
        n_checks++;
        if (n_resp != DEPTH || imem_rmask !== 4'h0) begin
            n_fail++;
            $display("FAIL stall_fill: got %0d responses rmask %h expected %0d rmask 0", n_resp, imem_rmask, DEPTH);
        end
        n_checks++;
        if (dec_valid !== 1'b1 || dec_pc !== RESET_PC) begin
            n_fail++;
            $display("FAIL stall_hold: got %b/%h expected 1/%h", dec_valid, dec_pc, RESET_PC);
        end
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1);
        n_checks++;
        if (dec_pc !== RESET_PC + 32'd4 || imem_rmask !== 4'hF || imem_addr !== RESET_PC + 32'd16) begin
            n_fail++;
            $display("FAIL stall_release: got %h/%h/%h expected %h/f/%h", dec_pc, imem_rmask, imem_addr, RESET_PC + 32'd4, RESET_PC + 32'd16);
        end
        repeat (8) tick(1'b0, 1'b0, 32'h0, 1'b0, 1);
    endtask

    task automatic test_flush_outstanding();
        bit found;
        mem_lat = 0;
        found = 1'b0;
        tick(1'b1, 1'b0, 32'h0, 1'b0, 0);
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_rmask === 4'hF && imem_addr === RESET_PC + 32'd12) found = 1'b1;
            else tick(1'b0, 1'b0, 32'h0, 1'b0, 1);
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL flush_reach_00c: got addr %h expected %h within 20 cycles", imem_addr, RESET_PC + 32'd12);
        end
        tick(1'b0, 1'b1, 32'h1eceb100, 1'b0, 0);
        n_checks++;
        if (dec_valid !== 1'b0 || imem_rmask !== 4'hF || imem_addr !== RESET_PC + 32'd12) begin
            n_fail++;
            $display("FAIL flush_discard: got %b/%h/%h expected 0/f/%h", dec_valid, imem_rmask, imem_addr, RESET_PC + 32'd12);
        end
        repeat (2) tick(1'b0, 1'b0, 32'h0, 1'b0, 0);
        tick(1'b0, 1'b0, 32'h0, 1'b0, 2);
        n_checks++;
        if (dec_valid !== 1'b0 || imem_rmask !== 4'h0) begin
            n_fail++;
            $display("FAIL flush_stale_drop: got %b/%h expected 0/0", dec_valid, imem_rmask);
        end
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1);
        n_checks++;
        if (imem_rmask !== 4'hF || imem_addr !== 32'h1eceb100 || dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_redirect_req: got %h/%h/%b expected f/1eceb100/0", imem_rmask, imem_addr, dec_valid);
        end
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1);
        n_checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h1eceb100) begin
            n_fail++;
            $display("FAIL flush_redirect_data: got %b/%h expected 1/1eceb100", dec_valid, dec_pc);
        end
    endtask

    task automatic test_flush_with_resp();
        logic [31:0] rpc;
        mem_lat = 0;
        rpc = $urandom | 32'h3;
        tick(1'b1, 1'b0, 32'h0, 1'b0, 0);
        repeat (3) tick(1'b0, 1'b0, 32'h0, 1'b0, 1);
        n_checks++;
        if (imem_rmask !== 4'hF) begin
            n_fail++;
            $display("FAIL flushresp_pre: got rmask %h expected f", imem_rmask);
        end
        tick(1'b0, 1'b1, rpc, 1'b0, 2);
        n_checks++;
        if (imem_rmask !== 4'h0 || dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flushresp_idle: got %h/%b expected 0/0", imem_rmask, dec_valid);
        end
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1);
        n_checks++;
        if (imem_rmask !== 4'hF || imem_addr !== {rpc[31:2], 2'b00}) begin
            n_fail++;
            $display("FAIL flushresp_req: got %h/%h expected f/%h", imem_rmask, imem_addr, {rpc[31:2], 2'b00});
        end
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1);
        n_checks++;
        if (dec_valid !== 1'b1 || dec_pc !== {rpc[31:2], 2'b00}) begin
            n_fail++;
            $display("FAIL flushresp_data: got %b/%h expected 1/%h", dec_valid, dec_pc, {rpc[31:2], 2'b00});
        end
    endtask

    task automatic test_rst_mid_read();
        mem_lat = 5;
        tick(1'b1, 1'b0, 32'h0, 1'b0, 0);
        repeat (3) tick(1'b0, 1'b0, 32'h0, 1'b0, 1);
        tick(1'b1, 1'b0, 32'h0, 1'b0, 0);
        tick(1'b0, 1'b0, 32'h0, 1'b0, 2);
        n_checks++;
        if (dec_valid !== 1'b0 || imem_rmask !== 4'hF || imem_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL rst_stray_resp: got %b/%h/%h expected 0/f/%h", dec_valid, imem_rmask, imem_addr, RESET_PC);
        end
        mem_lat = 0;
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1);
        n_checks++;
        if (dec_valid !== 1'b1 || dec_pc !== RESET_PC) begin
            n_fail++;
            $display("FAIL rst_restart: got %b/%h expected 1/%h", dec_valid, dec_pc, RESET_PC);
        end
    endtask

    task automatic test_random();
        bit          st;
        bit          fl;
        logic [31:0] rpc;
        tick(1'b1, 1'b0, 32'h0, 1'b0, 0);
        for (int i = 0; i < 600; i++) begin
            st      = ($urandom_range(0, 99) < 40);
            fl      = ($urandom_range(0, 99) < 4);
            rpc     = $urandom;
            mem_lat = $urandom_range(0, 2);
            tick(1'b0, fl, rpc, st, 1);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; redirect_pc = 32'h0; dec_stall = 1'b0;
        imem_resp = 1'b0; imem_rdata = 32'h0;
        n_checks = 0; n_fail = 0; mon_en = 1'b0; stale = 1'b0;
        mem_lat = 0; wait_ctr = 0; n_resp = 0;
        model_pc = RESET_PC; stale_addr = RESET_PC;
        test_reset();
        test_sequential();
        test_stall();
        test_flush_outstanding();
        test_flush_with_resp();
        test_rst_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
